traffic_req_gen: RTL and testbench

TRAFFIC_REQ_GEN -- requirements
Module: traffic_req_gen

---
 rtl/traffic_pkg.sv | 33 +++
 rtl/btn_debounce.sv | 74 +++++++
 rtl/traffic_req_gen.sv | 166 ++++++++++++++++
 tb/tb_traffic_req_gen.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traffic_pkg
// Brief    : Shared state encoding, parameter defaults and lamp helper for the
//            priority-request generator.
// Revision : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    // Parameter defaults used by traffic_req_gen and btn_debounce
    localparam int unsigned C_DEB_CYC     = 16;
    localparam int unsigned C_HOLD_SEC    = 10;
    localparam int unsigned C_COOL_SEC    = 5;
    localparam int unsigned C_CONFIRM_SEC = 2;

    // Width of the per-state tick counter (saturating)
    localparam int unsigned C_TCNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HOLD1 = 3'd1,
        S_HOLD2 = 3'd2,
        S_COOL  = 3'd3,
        S_FAULT = 3'd4
    } state_e;

    // True when exactly one of the three lamps of a road is lit
    function automatic logic lamp_one_lit(input logic r, input logic g, input logic y);
        return (r ^ g ^ y) & ~(r & g & y);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Brief    : Two-flop synchronizer plus stability debouncer for one raw button.
//            'rise' pulses for one cycle when the debounced level goes 0->1,
//            but only once the synchronized input has been seen low after
//            reset, so a button held through reset release is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce
    import traffic_pkg::*;
#(
    parameter int unsigned DEB_CYC = C_DEB_CYC
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise
);

    localparam int unsigned          C_CNT_W    = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [C_CNT_W-1:0]   C_CNT_LAST = C_CNT_W'(DEB_CYC - 1);

    logic               sync1_q;
    logic               sync2_q;
    logic [1:0]         vld_q;
    logic               arm_q;
    logic [C_CNT_W-1:0] cnt_q;
    logic               dout_q;
    logic               rise_q;

    // Synchronizer; vld_q[1] marks that sync2_q holds a genuinely sampled value
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            vld_q   <= 2'b00;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            vld_q   <= {vld_q[0], 1'b1};
        end
    end

    // Accept a new level after DEB_CYC consecutive differing samples
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            dout_q <= 1'b0;
            rise_q <= 1'b0;
            arm_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            if (sync2_q == dout_q) begin
                cnt_q <= '0;
            end else if (cnt_q == C_CNT_LAST) begin
                cnt_q  <= '0;
                dout_q <= sync2_q;
                rise_q <= sync2_q & arm_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (vld_q[1] && !sync2_q) begin
                arm_q <= 1'b1;
            end
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;

endmodule
`default_nettype wire

// File: rtl/traffic_req_gen.sv
`default_nettype none
// ============================================================================
// Module   : traffic_req_gen
// Brief    : Turns debounced priority-button presses into timed hold requests
//            for a two-road light controller, with cool-down, green-confirm
//            timeout and sticky lamp-conflict fault.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_req_gen
    import traffic_pkg::*;
#(
    parameter int unsigned DEB_CYC     = C_DEB_CYC,
    parameter int unsigned HOLD_SEC    = C_HOLD_SEC,
    parameter int unsigned COOL_SEC    = C_COOL_SEC,
    parameter int unsigned CONFIRM_SEC = C_CONFIRM_SEC
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic tick,
    input  logic btn1,
    input  logic btn2,
    input  logic r1,
    input  logic g1,
    input  logic y1,
    input  logic r2,
    input  logic g2,
    input  logic y2,
    output logic hold1,
    output logic hold2,
    output logic busy,
    output logic fault
);

    // Counter value seen on the tick that completes each timed interval
    localparam logic [C_TCNT_W-1:0] C_HOLD_LAST = C_TCNT_W'(HOLD_SEC - 1);
    localparam logic [C_TCNT_W-1:0] C_COOL_LAST = C_TCNT_W'(COOL_SEC - 1);
    localparam logic [C_TCNT_W-1:0] C_CONF_LAST = C_TCNT_W'(CONFIRM_SEC - 1);

    state_e                state_q, state_d;
    logic                  pend1_q, pend1_d;
    logic                  pend2_q, pend2_d;
    logic                  seen_q;
    logic [C_TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                  hold1_q, hold2_q, busy_q, fault_q;

    logic w_rise1, w_rise2, w_lvl1, w_lvl2;
    logic w_conflict, w_green, w_seen, w_unused;

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_btn1 (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .din    (btn1),
        .dout   (w_lvl1),
        .rise   (w_rise1)
    );

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_btn2 (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .din    (btn2),
        .dout   (w_lvl2),
        .rise   (w_rise2)
    );

    // Debounced levels are not needed here; only the press pulses are
    assign w_unused = w_lvl1 | w_lvl2;

    assign w_conflict = (g1 & g2) | ~lamp_one_lit(r1, g1, y1) | ~lamp_one_lit(r2, g2, y2);
    assign w_green    = ((state_q == S_HOLD1) & g1) | ((state_q == S_HOLD2) & g2);
    assign w_seen     = seen_q | w_green;

    // Next-state, pending-flag and tick-counter logic
    always_comb begin
        state_d = state_q;
        pend1_d = pend1_q;
        pend2_d = pend2_q;
        case (state_q)
            S_IDLE: begin
                if (pend1_q | w_rise1) begin
                    state_d = S_HOLD1;
                    pend1_d = 1'b0;
                    pend2_d = pend2_q | w_rise2;
                end else if (pend2_q | w_rise2) begin
                    state_d = S_HOLD2;
                    pend2_d = 1'b0;
                end
            end
            S_HOLD1: begin
                pend2_d = pend2_q | w_rise2;
                if (tick && tcnt_q == C_CONF_LAST && !w_seen) begin
                    state_d = S_FAULT;
                end else if (tick && tcnt_q == C_HOLD_LAST) begin
                    state_d = S_COOL;
                end
            end
            S_HOLD2: begin
                pend1_d = pend1_q | w_rise1;
                if (tick && tcnt_q == C_CONF_LAST && !w_seen) begin
                    state_d = S_FAULT;
                end else if (tick && tcnt_q == C_HOLD_LAST) begin
                    state_d = S_COOL;
                end
            end
            S_COOL: begin
                pend1_d = pend1_q | w_rise1;
                pend2_d = pend2_q | w_rise2;
                if (tick && tcnt_q == C_COOL_LAST) begin
                    state_d = S_IDLE;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
        if (w_conflict) begin
            state_d = S_FAULT;
        end
        if (state_d == S_FAULT) begin
            pend1_d = 1'b0;
            pend2_d = 1'b0;
        end
        // Counter restarts on every state entry; the entry-cycle tick is lost
        if (state_d != state_q) begin
            tcnt_d = '0;
        end else if (tick && tcnt_q != {C_TCNT_W{1'b1}}) begin
            tcnt_d = tcnt_q + 1'b1;
        end else begin
            tcnt_d = tcnt_q;
        end
    end

    // FSM state and registered outputs decoded from the next state
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pend1_q <= 1'b0;
            pend2_q <= 1'b0;
            seen_q  <= 1'b0;
            tcnt_q  <= '0;
            hold1_q <= 1'b0;
            hold2_q <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend1_q <= pend1_d;
            pend2_q <= pend2_d;
            seen_q  <= (state_d != state_q) ? 1'b0 : w_seen;
            tcnt_q  <= tcnt_d;
            hold1_q <= (state_d == S_HOLD1);
            hold2_q <= (state_d == S_HOLD2);
            busy_q  <= (state_d != S_IDLE);
            fault_q <= (state_d == S_FAULT);
        end
    end

    assign hold1 = hold1_q;
    assign hold2 = hold2_q;
    assign busy  = busy_q;
    assign fault = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_req_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_req_gen
// Brief    : Self-checking bench: directed scenarios with literal expectations
//            plus randomized traffic against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_traffic_req_gen;

    localparam int DEB  = 4;
    localparam int HOLD = 3;
    localparam int COOL = 2;
    localparam int CONF = 2;

    localparam int SIG_H1 = 0;
    localparam int SIG_H2 = 1;
    localparam int SIG_BUSY = 2;
    localparam int SIG_FAULT = 3;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b1;
    logic tick   = 1'b0;
    logic btn1   = 1'b0;
    logic btn2   = 1'b0;
    logic r1 = 1'b0, g1 = 1'b1, y1 = 1'b0;
    logic r2 = 1'b1, g2 = 1'b0, y2 = 1'b0;
    logic hold1, hold2, busy, fault;

    traffic_req_gen #(
        .DEB_CYC     (DEB),
        .HOLD_SEC    (HOLD),
        .COOL_SEC    (COOL),
        .CONFIRM_SEC (CONF)
    ) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .tick   (tick),
        .btn1   (btn1),
        .btn2   (btn2),
        .r1     (r1),
        .g1     (g1),
        .y1     (y1),
        .r2     (r2),
        .g2     (g2),
        .y2     (y2),
        .hold1  (hold1),
        .hold2  (hold2),
        .busy   (busy),
        .fault  (fault)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural reference model ----------------
    typedef enum int {M_IDLE, M_H1, M_H2, M_COOL, M_FAULT} mmode_t;
    mmode_t         m_mode;
    int             m_left;       // ticks still to run in the current timed state
    int             m_conf_left;  // ticks left for the requested green to show
    bit             m_seen;
    bit             m_pend [2];
    bit             m_s1 [2];
    bit             m_s2 [2];
    bit             m_lvl [2];
    bit             m_armed [2];
    bit             m_press [2];
    bit [DEB-1:0]   m_hist [2];
    int             m_edges;
    logic [3:0]     exp_out = 4'b0000;   // {hold1, hold2, busy, fault}

    function automatic void model_outputs();
        exp_out = {m_mode == M_H1, m_mode == M_H2, m_mode != M_IDLE, m_mode == M_FAULT};
    endfunction

    function automatic void model_reset();
        m_mode = M_IDLE; m_left = 0; m_conf_left = 0; m_seen = 0; m_edges = 0;
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 0; m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0;
            m_armed[i] = 0; m_press[i] = 0; m_hist[i] = '0;
        end
        model_outputs();
    endfunction

    function automatic void enter(input mmode_t md, input int len);
        m_mode = md; m_left = len; m_conf_left = CONF; m_seen = 0;
    endfunction

    // One clock edge: the FSM consumes last cycle's press pulses, then the
    // button front-ends produce this cycle's pulses.
    function automatic void model_step();
        bit b [2];
        bit conflict, want1, want2, green, s2used;
        int me, other;
        b[0] = btn1; b[1] = btn2;
        conflict = (g1 && g2) || ((int'(r1) + int'(g1) + int'(y1)) != 1)
                              || ((int'(r2) + int'(g2) + int'(y2)) != 1);
        if (conflict) begin
            m_mode = M_FAULT;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    want1 = m_pend[0] || m_press[0];
                    want2 = m_pend[1] || m_press[1];
                    if (want1) begin
                        enter(M_H1, HOLD); m_pend[0] = 0; m_pend[1] = want2;
                    end else if (want2) begin
                        enter(M_H2, HOLD); m_pend[1] = 0;
                    end
                end
                M_H1, M_H2: begin
                    me = (m_mode == M_H1) ? 0 : 1;
                    other = 1 - me;
                    if (m_press[other]) m_pend[other] = 1;
                    green = (me == 0) ? g1 : g2;
                    if (green) m_seen = 1;
                    if (tick) begin
                        m_left--; m_conf_left--;
                        if (m_conf_left == 0 && !m_seen) m_mode = M_FAULT;
                        else if (m_left == 0) enter(M_COOL, COOL);
                    end
                end
                M_COOL: begin
                    for (int i = 0; i < 2; i++) if (m_press[i]) m_pend[i] = 1;
                    if (tick) begin
                        m_left--;
                        if (m_left == 0) m_mode = M_IDLE;
                    end
                end
                default: ;
            endcase
        end
        if (m_mode == M_FAULT) begin
            m_pend[0] = 0; m_pend[1] = 0;
        end
        for (int i = 0; i < 2; i++) begin
            s2used = m_s2[i];
            m_hist[i] = {m_hist[i][DEB-2:0], s2used};
            m_press[i] = 0;
            if (m_hist[i] == {DEB{~m_lvl[i]}}) begin
                m_lvl[i] = ~m_lvl[i];
                m_press[i] = m_lvl[i] && m_armed[i];
            end
            if (m_edges >= 2 && !s2used) m_armed[i] = 1;
            m_s2[i] = m_s1[i];
            m_s1[i] = b[i];
        end
        m_edges++;
        model_outputs();
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_in) begin
        checks++;
        if ({hold1, hold2, busy, fault} !== exp_out) begin
            errors++;
            $display("FAIL cycle_compare t=%0t got {h1,h2,busy,fault}=%b expected %b",
                     $time, {hold1, hold2, busy, fault}, exp_out);
        end
    end

    // ---------------- stimulus helpers ----------------
    int tick_per = 5;
    int tick_ph  = 0;
    int lamp_mode = 0;     // 1: road 1 never shows green
    bit inject = 0;
    int inject_kind = 0;
    int th1 = 0, th2 = 0, tcool = 0;

    task automatic set_lamps();
        if (m_mode == M_H2) begin
            {r1, g1, y1} = 3'b100; {r2, g2, y2} = 3'b010;
        end else begin
            {r1, g1, y1} = 3'b010; {r2, g2, y2} = 3'b100;
        end
        if (lamp_mode == 1) {r1, g1, y1} = 3'b100;
        if (inject) begin
            case (inject_kind)
                0:       begin g1 = 1'b1; g2 = 1'b1; end
                1:       {r1, g1, y1} = 3'b000;
                default: y2 = 1'b1;
            endcase
            inject = 0;
        end
    endtask

    task automatic cycle();
        @(negedge clk_in);
        if (tick) begin
            if (hold1) th1++;
            if (hold2) th2++;
            if (busy && !hold1 && !hold2 && !fault) tcool++;
        end
        @(posedge clk_in);
        #1;
        if (rst_n) model_step();
        tick_ph++;
        if (tick_per > 0) tick = ((tick_ph % tick_per) == 0);
        else              tick = ($urandom_range(0, 3) == 0);
        set_lamps();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        repeat (n) cycle();
        rst_n = 1'b1;
    endtask

    function automatic logic sig(input int which);
        case (which)
            SIG_H1:   return hold1;
            SIG_H2:   return hold2;
            SIG_BUSY: return busy;
            default:  return fault;
        endcase
    endfunction

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %b want %b", name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic wait_sig(input string name, input int which, input logic val, input int maxc);
        int n;
        n = 0;
        while (sig(which) !== val && n < maxc) begin
            cycle();
            n++;
        end
        if (sig(which) !== val) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s got %b want %b after %0d cycles", name, sig(which), val, maxc);
        end
    endtask

    // ---------------- main sequence ----------------
    int dur [2];
    bit lvl [2];

    initial begin
        model_reset();
        #1;
        rst_n = 1'b0;
        #1;
        check_bit("reset_hold1", hold1, 1'b0);
        check_bit("reset_busy",  busy,  1'b0);
        check_bit("reset_fault", fault, 1'b0);
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (5) cycle();

        // Short glitch is rejected; a long press gives 3 hold ticks, 2 cool ticks
        btn1 = 1; repeat (3) cycle(); btn1 = 0;
        repeat (20) cycle();
        check_bit("glitch_no_hold", hold1, 1'b0);
        check_bit("glitch_no_busy", busy,  1'b0);
        th1 = 0; tcool = 0;
        btn1 = 1; repeat (10) cycle(); btn1 = 0;
        wait_sig("s1_hold1", SIG_H1, 1'b1, 40);
        wait_sig("s1_idle", SIG_BUSY, 1'b0, 100);
        check_int("s1_hold_ticks", th1, 3);
        check_int("s1_cool_ticks", tcool, 2);

        // Simultaneous presses: road 1 first, road 2 after cool-down
        th1 = 0; th2 = 0; tcool = 0;
        btn1 = 1; btn2 = 1; repeat (8) cycle(); btn1 = 0; btn2 = 0;
        wait_sig("s2_hold1", SIG_H1, 1'b1, 40);
        wait_sig("s2_hold2", SIG_H2, 1'b1, 150);
        check_int("s2_hold1_ticks", th1, 3);
        check_int("s2_cool_ticks", tcool, 2);
        wait_sig("s2_idle", SIG_BUSY, 1'b0, 100);
        check_int("s2_hold2_ticks", th2, 3);

        // Press on the held road is dropped
        tick_per = 10; th1 = 0;
        btn1 = 1;
        wait_sig("s3_hold1", SIG_H1, 1'b1, 40);
        btn1 = 0; repeat (6) cycle();
        btn1 = 1; repeat (6) cycle(); btn1 = 0;
        check_bit("s3_still_held", hold1, 1'b1);
        wait_sig("s3_idle", SIG_BUSY, 1'b0, 150);
        repeat (40) cycle();
        check_bit("s3_stays_idle", busy, 1'b0);
        check_int("s3_hold_ticks", th1, 3);
        tick_per = 5;

        // Green never appears: fault at the 2nd tick, presses ignored after
        lamp_mode = 1; th1 = 0;
        btn1 = 1;
        wait_sig("s4_hold1", SIG_H1, 1'b1, 40);
        btn1 = 0;
        wait_sig("s4_fault", SIG_FAULT, 1'b1, 60);
        check_int("s4_ticks_to_fault", th1, 2);
        check_bit("s4_hold1_off", hold1, 1'b0);
        btn2 = 1; repeat (10) cycle(); btn2 = 0;
        repeat (30) cycle();
        check_bit("s4_fault_sticky", fault, 1'b1);
        check_bit("s4_no_hold2", hold2, 1'b0);
        lamp_mode = 0;
        do_reset(3);
        repeat (5) cycle();

        // Both greens for one cycle while idle
        inject = 1; inject_kind = 0;
        cycle();
        check_bit("s5_before_edge", fault, 1'b0);
        cycle();
        check_bit("s5_fault", fault, 1'b1);
        repeat (10) cycle();
        check_bit("s5_fault_sticky", fault, 1'b1);
        do_reset(3);
        repeat (5) cycle();

        // Asynchronous reset mid-hold; button held through release is ignored
        btn2 = 1;
        wait_sig("s6_hold2", SIG_H2, 1'b1, 40);
        repeat (3) cycle();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_bit("s6_async_hold2", hold2, 1'b0);
        check_bit("s6_async_busy", busy, 1'b0);
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (30) cycle();
        check_bit("s6_held_btn_ignored", busy, 1'b0);
        btn2 = 0; repeat (10) cycle();
        btn2 = 1;
        wait_sig("s6_repress_hold2", SIG_H2, 1'b1, 40);
        btn2 = 0;
        wait_sig("s6_idle", SIG_BUSY, 1'b0, 100);

        // Randomized episodes
        tick_per = 0;
        for (int ep = 0; ep < 8; ep++) begin
            do_reset(2);
            lamp_mode = (ep == 3) ? 1 : 0;
            dur[0] = 0; dur[1] = 0; lvl[0] = 0; lvl[1] = 0;
            for (int c = 0; c < 500; c++) begin
                for (int i = 0; i < 2; i++) begin
                    if (dur[i] == 0) begin
                        lvl[i] = ($urandom_range(0, 2) == 0);
                        dur[i] = $urandom_range(1, 14);
                    end
                    dur[i]--;
                end
                btn1 = lvl[0];
                btn2 = lvl[1];
                if (ep >= 5 && $urandom_range(0, 249) == 0) begin
                    inject = 1;
                    inject_kind = $urandom_range(0, 2);
                end
                cycle();
            end
            lamp_mode = 0;
        end
        btn1 = 0; btn2 = 0;
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
